cnn_window_gen: RTL and testbench
=================================

CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

Interface
REQ-001 Parameter IMG_W, default 16, image width in pixels; legal range 2..1024.
REQ-002 Parameter IMG_H, default 16, image height in pixels; legal range 2..1024.
REQ-003 Parameter BORDER_VAL, default 8'd0, value substituted for out-of-image neighbours.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input pixel valid.
REQ-007 in_ready  out  1  block accepts a pixel when in_valid && in_ready.
REQ-008 in_pixel  in  8  unsigned pixel (U value), raster order.
REQ-009 out_valid  out  1  window valid.
REQ-010 out_ready  in  1  downstream cell accepts the window when out_valid && out_ready.
REQ-011 W1..W9  out  8 each  3x3 neighbourhood, row-major: W1 top-left, W5 centre, W9 bottom-right; these drive the cell's U1..U9 inputs.
REQ-012 out_row, out_col  out  10 each  centre coordinates of the current window.
REQ-013 out_last  out  1  high with the window centred at (IMG_H-1, IMG_W-1).

Function
REQ-014 States: FILL (accept pixels, no output yet), RUN (accept pixels, emit windows), FLUSH (no input, emit remaining windows).
REQ-015 Window q (raster index of its centre) becomes valid the cycle after input pixel q+IMG_W+1 is accepted; the lag is uniform.
REQ-016 FILL -> RUN on acceptance of pixel index IMG_W+1; RUN -> FLUSH on acceptance of pixel IMG_W*IMG_H-1; FLUSH emits exactly IMG_W+1 windows, then returns to FILL.
REQ-017 Neighbours with row or column outside 0..IMG_H-1 / 0..IMG_W-1 equal BORDER_VAL; no wrap-around between rows or frames.
REQ-018 Single registered output stage: W1..W9, out_row, out_col and out_last are held stable while out_valid && !out_ready.
REQ-019 in_ready = (state != FLUSH) && !(out_valid && !out_ready); at most one pixel is accepted and one window emitted per cycle.
REQ-020 With out_ready held high and in_valid held high, throughput is one window per cycle.
REQ-021 Pixels are passed through unmodified (no arithmetic); column and row counters wrap at IMG_W-1 and IMG_H-1.
REQ-022 Exactly IMG_W*IMG_H windows are emitted per frame; back-to-back frames are separated only by FLUSH.

Reset
REQ-023 While rst is high: state=FILL, all counters 0, out_valid=0, out_last=0, W1..W9=0, out_row=out_col=0, in_ready=0.
REQ-024 A reset asserted mid-frame discards all buffered pixels and any pending window; the first pixel after reset is treated as pixel (0,0).

Configuration
REQ-025 Macro CNN_WIN_REPLICATE_EN: when defined, out-of-image neighbours take the value of the nearest in-image pixel (edge replication) and BORDER_VAL is ignored; when undefined, REQ-017 applies.

Structure
REQ-026 Package cnn_pkg holds PIX_W=8, Y_W=9 (cell output width), COORD_W=10, the window-state enum and a 9-element pixel-window typedef.
REQ-027 One sub-module, cnn_line_buf: an IMG_W-deep, 8-bit delay line instantiated twice (rows r-1 and r); the 3x3 shift register, border masking and FSM remain in cnn_window_gen.

Verification (IMG_W=4, IMG_H=3, pixels 1..12, BORDER_VAL=0 unless stated)
REQ-028 Stream all pixels with out_ready=1 -> first out_valid the cycle after pixel 6 is accepted; window(0,0) = 0,0,0,0,1,2,0,5,6.
REQ-029 Same stream -> window(1,1) = 1,2,3,5,6,7,9,10,11; window(2,3) = 7,8,0,11,12,0,0,0,0 with out_last=1; 12 windows in total, 5 of them emitted in FLUSH with in_ready=0.
REQ-030 Hold out_ready=0 for 3 cycles while window(0,1) is valid -> outputs stable, in_ready=0, no pixel lost; the full sequence is identical to REQ-028/029.
REQ-031 Assert rst after pixel 7 is accepted, then send a fresh frame 1..12 -> output matches REQ-028/029 exactly, with no stale window.
REQ-032 With CNN_WIN_REPLICATE_EN defined -> window(0,0) = 1,1,2,1,1,2,5,5,6; window(2,3) = 7,8,8,11,12,12,11,12,12.
REQ-033 Two frames sent back-to-back with random in_valid/out_ready gaps -> 24 windows; the second frame's window(0,0) equals the first frame's.

Source files
------------

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg -- shared widths and types for the CNN 3x3 window generator.
//   PIX_W   : pixel width (unsigned U value)
//   Y_W     : width of the downstream cell output
//   COORD_W : width of the row/column coordinate outputs
//   win_state_e : window generator FSM states
//   pix_win_t   : 3x3 pixel window, element 0 = W1 (top-left) .. 8 = W9
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int PIX_W   = 8;
  localparam int Y_W     = 9;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,  // accepting pixels, no window complete yet
    ST_RUN   = 2'd1,  // accepting pixels and emitting windows
    ST_FLUSH = 2'd2   // input closed, draining the last IMG_W+1 windows
  } win_state_e;

  typedef logic [8:0][PIX_W-1:0] pix_win_t;

endpackage

// File: rtl/cnn_line_buf.sv
// ---------------------------------------------------------------------------
// cnn_line_buf -- DEPTH-deep delay line (one image row of pixels).
// dout_o is the value written DEPTH enabled steps earlier; it is valid in the
// same cycle as en_i so the caller can consume it while pushing din_i.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pointer only)
//   en_i     : advance the delay line by one pixel
//   din_i    : pixel entering the line
//   dout_o   : pixel leaving the line (DEPTH steps old)
// The storage has no reset: stale contents only ever reach out-of-image
// window positions, which are masked by the window generator.
// ---------------------------------------------------------------------------
module cnn_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Read-before-write circular buffer: the slot about to be overwritten
  // holds the oldest sample.
  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// ---------------------------------------------------------------------------
// cnn_window_gen -- streams a raster image in and emits one 3x3 neighbourhood
// per pixel (centre in raster order) for a CNN cell.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : pixel input handshake, in_pixel = unsigned pixel
//   out_valid/out_ready : window output handshake
//   W1..W9              : window, row-major (W1 top-left, W5 centre)
//   out_row, out_col    : centre coordinates of the presented window
//   out_last            : presented window is centred on the last pixel
//   dbg_state           : current FSM state (observation only)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. out_valid and the window payload hold steady until accepted;
// in_ready never depends on in_valid.
//
// Optional build macro CNN_WIN_REPLICATE_EN: out-of-image neighbours copy
// the nearest in-image pixel instead of taking BORDER_VAL.
//
// Datapath: two row delay lines give pixels p-IMG_W and p-2*IMG_W alongside
// the incoming pixel p. Two stored columns plus this fresh column form the
// raw 3x3 neighbourhood centred on p-IMG_W-1; it is masked using the centre
// counter and registered into the single output stage in the same edge that
// accepts p.
// ---------------------------------------------------------------------------
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int               IMG_W      = 16,
  parameter int               IMG_H      = 16,
  parameter logic [PIX_W-1:0] BORDER_VAL = 8'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   W1,
  output logic [PIX_W-1:0]   W2,
  output logic [PIX_W-1:0]   W3,
  output logic [PIX_W-1:0]   W4,
  output logic [PIX_W-1:0]   W5,
  output logic [PIX_W-1:0]   W6,
  output logic [PIX_W-1:0]   W7,
  output logic [PIX_W-1:0]   W8,
  output logic [PIX_W-1:0]   W9,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col,
  output logic               out_last,
  output win_state_e         dbg_state
);

  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMG_H - 1);

  win_state_e state_q, state_d;

  // Next input pixel position and next window centre position.
  logic [COORD_W-1:0] in_col_q, in_col_d, in_row_q, in_row_d;
  logic [COORD_W-1:0] cen_col_q, cen_col_d, cen_row_q, cen_row_d;

  // Columns indexed [0]=top (p-2W), [1]=mid (p-W), [2]=bottom (p).
  logic [2:0][PIX_W-1:0] col_a_q, col_b_q, col_c;
  logic [2:0][2:0][PIX_W-1:0] cols;   // cols[column][row]
  logic [PIX_W-1:0] row_m1_pix, row_m2_pix;

  pix_win_t           win_d, win_q;
  logic               out_valid_q, out_last_q;
  logic [COORD_W-1:0] out_row_q, out_col_q;

  logic       out_free, accept, step, load;
  logic       in_at_fill, in_at_last, cen_last;
  logic [2:0] row_out, col_out;

  // ---------------- handshake ----------------
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !rst && (state_q != ST_FLUSH) && out_free;
  assign accept   = in_valid && in_ready;
  // The pipeline advances on every accepted pixel and, while flushing, on
  // every cycle the output stage can take a new window.
  assign step     = accept || ((state_q == ST_FLUSH) && out_free);

  assign in_at_fill = (in_row_q == COORD_W'(1)) && (in_col_q == COORD_W'(1));
  assign in_at_last = (in_row_q == ROW_MAX) && (in_col_q == COL_MAX);
  assign cen_last   = (cen_row_q == ROW_MAX) && (cen_col_q == COL_MAX);

  // ---------------- row delay lines ----------------
  cnn_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_r1 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (step),
    .din_i  (in_pixel),
    .dout_o (row_m1_pix)
  );

  cnn_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_r2 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (step),
    .din_i  (row_m1_pix),
    .dout_o (row_m2_pix)
  );

  // During flush in_pixel is a don't-care: it only lands in positions that
  // are outside the image and therefore masked.
  assign col_c[0] = row_m2_pix;
  assign col_c[1] = row_m1_pix;
  assign col_c[2] = in_pixel;

  assign cols[0] = col_a_q;
  assign cols[1] = col_b_q;
  assign cols[2] = col_c;

  // ---------------- border masking ----------------
  always_comb begin
    row_out = {cen_row_q == ROW_MAX, 1'b0, cen_row_q == '0};
    col_out = {cen_col_q == COL_MAX, 1'b0, cen_col_q == '0};
    win_d   = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
`ifdef CNN_WIN_REPLICATE_EN
        // Outside rows/columns fold onto the centre row/column, which is
        // always inside the image; corners fold in both directions.
        win_d[r*3+c] = cols[col_out[c] ? 1 : c][row_out[r] ? 1 : r];
`else
        win_d[r*3+c] = (row_out[r] || col_out[c]) ? BORDER_VAL : cols[c][r];
`endif
      end
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (accept && in_at_fill) begin
          load    = 1'b1;
          // Tiny images can complete the frame on the very first window.
          state_d = in_at_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          load = 1'b1;
          if (in_at_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (step) begin
          load = 1'b1;
          if (cen_last) state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // ---------------- coordinate counters ----------------
  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    cen_col_d = cen_col_q;
    cen_row_d = cen_row_q;
    if (accept) begin
      if (in_col_q == COL_MAX) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_MAX) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
    if (load) begin
      if (cen_col_q == COL_MAX) begin
        cen_col_d = '0;
        cen_row_d = (cen_row_q == ROW_MAX) ? '0 : cen_row_q + 1'b1;
      end else begin
        cen_col_d = cen_col_q + 1'b1;
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      in_col_q    <= '0;
      in_row_q    <= '0;
      cen_col_q   <= '0;
      cen_row_q   <= '0;
      col_a_q     <= '0;
      col_b_q     <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      cen_col_q <= cen_col_d;
      cen_row_q <= cen_row_d;
      if (step) begin
        col_a_q <= col_b_q;
        col_b_q <= col_c;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        win_q       <= win_d;
        out_row_q   <= cen_row_q;
        out_col_q   <= cen_col_q;
        out_last_q  <= cen_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign W1        = win_q[0];
  assign W2        = win_q[1];
  assign W3        = win_q[2];
  assign W4        = win_q[3];
  assign W5        = win_q[4];
  assign W6        = win_q[5];
  assign W7        = win_q[6];
  assign W8        = win_q[7];
  assign W9        = win_q[8];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// ---------------------------------------------------------------------------
// tb_cnn_window_gen -- directed bench for cnn_window_gen on a 4x3 image of
// pixels 1..12. Expected windows are a hand-computed table.
// ---------------------------------------------------------------------------
module tb_cnn_window_gen;
  import cnn_pkg::*;

  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int NPIX = IW * IH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0]   in_pixel;
  logic [7:0]   W1, W2, W3, W4, W5, W6, W7, W8, W9;
  logic [9:0]   out_row, out_col;
  win_state_e   dbg_state;

  cnn_window_gen #(.IMG_W(IW), .IMG_H(IH), .BORDER_VAL(8'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .W1        (W1),
    .W2        (W2),
    .W3        (W3),
    .W4        (W4),
    .W5        (W5),
    .W6        (W6),
    .W7        (W7),
    .W8        (W8),
    .W9        (W9),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  logic [95:0] out_pack;
  assign out_pack = {3'b000, W1, W2, W3, W4, W5, W6, W7, W8, W9,
                     out_row, out_col, out_last};

  // ---------------- scoreboard state ----------------
  logic [71:0] exp_tab [NPIX];
  logic [95:0] exp_q [$];
  logic [95:0] got_q [$];
  logic [95:0] stall_q [$];
  logic        stall_rdy_q [$];
  int tests_run    = 0;
  int tests_failed = 0;
  int first_vld_cyc, acc6_cyc, flush_wins;

  function automatic logic [71:0] win9(input logic [7:0] b1, b2, b3, b4, b5,
                                       b6, b7, b8, b9);
    return {b1, b2, b3, b4, b5, b6, b7, b8, b9};
  endfunction

  task automatic init_table();
`ifdef CNN_WIN_REPLICATE_EN
    exp_tab[0]  = win9(1, 1, 2,   1, 1, 2,    5, 5, 6);
    exp_tab[1]  = win9(1, 2, 3,   1, 2, 3,    5, 6, 7);
    exp_tab[2]  = win9(2, 3, 4,   2, 3, 4,    6, 7, 8);
    exp_tab[3]  = win9(3, 4, 4,   3, 4, 4,    7, 8, 8);
    exp_tab[4]  = win9(1, 1, 2,   5, 5, 6,    9, 9, 10);
    exp_tab[5]  = win9(1, 2, 3,   5, 6, 7,    9, 10, 11);
    exp_tab[6]  = win9(2, 3, 4,   6, 7, 8,    10, 11, 12);
    exp_tab[7]  = win9(3, 4, 4,   7, 8, 8,    11, 12, 12);
    exp_tab[8]  = win9(5, 5, 6,   9, 9, 10,   9, 9, 10);
    exp_tab[9]  = win9(5, 6, 7,   9, 10, 11,  9, 10, 11);
    exp_tab[10] = win9(6, 7, 8,   10, 11, 12, 10, 11, 12);
    exp_tab[11] = win9(7, 8, 8,   11, 12, 12, 11, 12, 12);
`else
    exp_tab[0]  = win9(0, 0, 0,   0, 1, 2,    0, 5, 6);
    exp_tab[1]  = win9(0, 0, 0,   1, 2, 3,    5, 6, 7);
    exp_tab[2]  = win9(0, 0, 0,   2, 3, 4,    6, 7, 8);
    exp_tab[3]  = win9(0, 0, 0,   3, 4, 0,    7, 8, 0);
    exp_tab[4]  = win9(0, 1, 2,   0, 5, 6,    0, 9, 10);
    exp_tab[5]  = win9(1, 2, 3,   5, 6, 7,    9, 10, 11);
    exp_tab[6]  = win9(2, 3, 4,   6, 7, 8,    10, 11, 12);
    exp_tab[7]  = win9(3, 4, 0,   7, 8, 0,    11, 12, 0);
    exp_tab[8]  = win9(0, 5, 6,   0, 9, 10,   0, 0, 0);
    exp_tab[9]  = win9(5, 6, 7,   9, 10, 11,  0, 0, 0);
    exp_tab[10] = win9(6, 7, 8,   10, 11, 12, 0, 0, 0);
    exp_tab[11] = win9(7, 8, 0,   11, 12, 0,  0, 0, 0);
`endif
  endtask

  // Expected packed output for the k-th window of a stream of frames.
  function automatic logic [95:0] exp_word(input int k);
    int i;
    i = k % NPIX;
    return {3'b000, exp_tab[i], 10'(i / IW), 10'(i % IW), (i == NPIX - 1)};
  endfunction

  task automatic load_exp(input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(exp_word(k));
  endtask

  // ---------------- driver ----------------
  // mode 0: always ready / valid; 1: random gaps on both sides;
  // 2: out_ready low for three cycles while window (0,1) is presented.
  // stop_pix > 0 ends the run once that many pixels have been accepted.
  task automatic run_stream(input int n_pix, input int n_win, input int mode,
                            input int stop_pix);
    int idx, nwin, cyc, stall_left;
    logic [95:0] snap;
    idx = 0; nwin = 0; cyc = 0; stall_left = 3;
    got_q.delete(); stall_q.delete(); stall_rdy_q.delete();
    first_vld_cyc = -1; acc6_cyc = -1; flush_wins = 0;
    while ((nwin < n_win || idx < n_pix) && cyc < 600 &&
           !(stop_pix > 0 && idx >= stop_pix)) begin
      @(negedge clk);
      snap = out_pack;
      if (mode == 1) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else if (mode == 2 && out_valid && out_row == 10'd0 &&
                   out_col == 10'd1 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (idx < n_pix) begin
        in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_pixel = 8'((idx % NPIX) + 1);
      end else begin
        in_valid = 1'b0;
        in_pixel = 8'd0;
      end
      #1;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_valid && !out_ready) begin
        stall_q.push_back(snap);
        stall_rdy_q.push_back(in_ready);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(snap);
        nwin++;
        if (!in_ready) flush_wins++;
      end
      if (in_valid && in_ready) begin
        if (idx == 5) acc6_cyc = cyc;
        idx++;
      end
      cyc++;
    end
    if (cyc >= 600) begin
      tests_run++;
      tests_failed++;
      $display("FAIL run_stream timeout: %0d windows got, %0d required", nwin, n_win);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    tests_run++;
    if (out_pack !== 96'd0) begin
      tests_failed++; $display("FAIL reset_outputs got %h exp 0", out_pack);
    end
    tests_run++;
    if (dbg_state !== ST_FILL) begin
      tests_failed++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_FILL);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_stream();
    load_exp(NPIX);
    run_stream(NPIX, NPIX, 0, 0);
    tests_run++;
    if (acc6_cyc < 0 || first_vld_cyc !== acc6_cyc + 1) begin
      tests_failed++;
      $display("FAIL stream_latency first valid cyc %0d exp %0d", first_vld_cyc, acc6_cyc + 1);
    end
    tests_run++;
    if (got_q.size() !== NPIX) begin
      tests_failed++; $display("FAIL stream_count got %0d exp %0d", got_q.size(), NPIX);
    end
    tests_run++;
    if (flush_wins !== IW + 1) begin
      tests_failed++; $display("FAIL stream_flush_windows got %0d exp %0d", flush_wins, IW + 1);
    end
    for (int i = 0; i < NPIX; i++) begin
      logic [95:0] g, e;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 96'hx;
      tests_run++;
      if (g !== e) begin
        tests_failed++; $display("FAIL stream_win%0d got %h exp %h", i, g, e);
      end
    end
    #1;
    tests_run++;
    if (dbg_state !== ST_FILL || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end_state got state %0d valid %b exp %0d 0", dbg_state, out_valid, ST_FILL);
    end
  endtask

  task automatic test_stall();
    load_exp(NPIX);
    run_stream(NPIX, NPIX, 2, 0);
    tests_run++;
    if (stall_q.size() !== 3) begin
      tests_failed++; $display("FAIL stall_cycles got %0d exp 3", stall_q.size());
    end
    for (int i = 0; i < stall_q.size(); i++) begin
      tests_run++;
      if (stall_q[i] !== exp_word(1) || stall_rdy_q[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d got %h rdy %b exp %h rdy 0", i, stall_q[i], stall_rdy_q[i], exp_word(1));
      end
    end
    tests_run++;
    if (got_q.size() !== NPIX) begin
      tests_failed++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      logic [95:0] g, e;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 96'hx;
      tests_run++;
      if (g !== e) begin
        tests_failed++; $display("FAIL stall_win%0d got %h exp %h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    run_stream(NPIX, 0, 0, 7);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dbg_state !== ST_FILL) begin
      tests_failed++;
      $display("FAIL midrst_clear got valid %b rdy %b state %0d exp 0 0 %0d", out_valid, in_ready, dbg_state, ST_FILL);
    end
    rst = 1'b0;
    load_exp(NPIX);
    run_stream(NPIX, NPIX, 0, 0);
    tests_run++;
    if (got_q.size() !== NPIX) begin
      tests_failed++; $display("FAIL midrst_count got %0d exp %0d", got_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      logic [95:0] g, e;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 96'hx;
      tests_run++;
      if (g !== e) begin
        tests_failed++; $display("FAIL midrst_win%0d got %h exp %h", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    load_exp(2 * NPIX);
    run_stream(2 * NPIX, 2 * NPIX, 1, 0);
    tests_run++;
    if (got_q.size() !== 2 * NPIX) begin
      tests_failed++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), 2 * NPIX);
    end
    for (int i = 0; i < 2 * NPIX; i++) begin
      logic [95:0] g, e;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 96'hx;
      tests_run++;
      if (g !== e) begin
        tests_failed++; $display("FAIL b2b_win%0d got %h exp %h", i, g, e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = 8'd0;
    out_ready = 1'b1;
    init_table();
    repeat (3) @(posedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
